// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader.
//   DEF_CLKS_PER_BIT : default clock cycles per UART bit (100 MHz / 115200 baud)
//   DEF_ADDR_W       : default instruction-memory word-address width
//   loaderState_t    : loader FSM states (reset state LEN_LO)
//   rxState_t        : serial receiver states
package loader_pkg;

    localparam int DEF_CLKS_PER_BIT = 868;
    localparam int DEF_ADDR_W       = 8;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        DONE,
        ERR
    } loaderState_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP
    } rxState_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, one byte buffered.
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   rx        : raw serial input (idle high), synchronized internally
//   rxByte    : last good byte, valid while byteValid is high
//   byteValid : one-cycle pulse at the stop-bit sample when stop=1
//   stopErr   : one-cycle pulse at the stop-bit sample when stop=0
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rxByte,
    output logic       byteValid,
    output logic       stopErr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rxMeta;
    logic             rxSync;
    rxState_t         state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bitIdx;
    logic [7:0]       shiftReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxMeta    <= 1'b1;
            rxSync    <= 1'b1;
            state     <= RX_IDLE;
            cnt       <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
            rxByte    <= '0;
            byteValid <= 1'b0;
            stopErr   <= 1'b0;
        end else begin
            rxMeta    <= rx;
            rxSync    <= rxMeta;
            byteValid <= 1'b0;
            stopErr   <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!rxSync) state <= RX_START;
                end
                // Re-check the line at mid start bit; a high here was a glitch.
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt    <= '0;
                        bitIdx <= '0;
                        state  <= rxSync ? RX_IDLE : RX_BITS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_BITS: begin
                    if (cnt == BIT_LAST) begin
                        cnt      <= '0;
                        shiftReg <= {rxSync, shiftReg[7:1]};
                        bitIdx   <= bitIdx + 1'b1;
                        if (bitIdx == 3'd7) state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rxSync) begin
                            rxByte    <= shiftReg;
                            byteValid <= 1'b1;
                        end else begin
                            stopErr <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// Loads a program image received over UART into instruction memory.
// Stream format: 16-bit little-endian word count N, then N 32-bit
// little-endian words. The core is held in reset until the load completes.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   rx         : UART serial input (8N1, idle high)
//   imem_we    : one-cycle write strobe per word
//   imem_addr  : word address of the current write
//   imem_wdata : word being written
//   core_rst   : processor reset, released only in DONE
//   load_done  : high once all N words are written
//   frame_err  : sticky; bad stop bit or word count above 2^ADDR_W
//   busy       : high from the first length byte until DONE or ERR
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int ADDR_W       = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              load_done,
    output logic              frame_err,
    output logic              busy
);

    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

    logic [7:0]    rxByte;
    logic          byteValid;
    logic          stopErr;
    loaderState_t  state;
    logic [7:0]    lenLo;
    logic [15:0]   wordCount;
    logic [15:0]   lenNext;
    // One extra bit so the index can reach N = 2^ADDR_W without wrapping.
    logic [ADDR_W:0] wordIdx;
    logic [1:0]    byteCnt;
    logic [23:0]   wordAcc;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rxByte   (rxByte),
        .byteValid(byteValid),
        .stopErr  (stopErr)
    );

    always_comb lenNext = {rxByte, lenLo};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LEN_LO;
            lenLo      <= '0;
            wordCount  <= '0;
            wordIdx    <= '0;
            byteCnt    <= '0;
            wordAcc    <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst   <= 1'b1;
            load_done  <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                LEN_LO: begin
                    if (stopErr) begin
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ERR;
                    end else if (byteValid) begin
                        lenLo <= rxByte;
                        busy  <= 1'b1;
                        state <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (stopErr) begin
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ERR;
                    end else if (byteValid) begin
                        wordCount <= lenNext;
                        if (lenNext == 16'd0) begin
                            core_rst  <= 1'b0;
                            load_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= DONE;
                        end else if (17'(lenNext) > MAX_WORDS) begin
                            frame_err <= 1'b1;
                            busy      <= 1'b0;
                            state     <= ERR;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    // Write cycle: advance the index, finish after word N-1.
                    if (imem_we) begin
                        wordIdx <= wordIdx + 1'b1;
                        if (17'(wordIdx) + 17'd1 == 17'(wordCount)) begin
                            core_rst  <= 1'b0;
                            load_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= DONE;
                        end
                    end
                    if (stopErr) begin
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ERR;
                    end else if (byteValid) begin
                        byteCnt <= byteCnt + 1'b1;
                        if (byteCnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= wordIdx[ADDR_W-1:0];
                            imem_wdata <= {rxByte, wordAcc};
                        end else begin
                            wordAcc <= {rxByte, wordAcc[23:8]};
                        end
                    end
                end
                DONE, ERR: ;
                default: state <= LEN_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader (CLKS_PER_BIT=4, ADDR_W=8).
// Byte streams are serialized onto rx; a stream-level reference model
// derives the expected memory writes and final status flags.
module tb_uart_program_loader;

    localparam int CPB = 4;
    localparam int AW  = 8;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst;
    logic          load_done;
    logic          frame_err;
    logic          busy;

    int total = 0;
    int bad   = 0;
    string testName = "init";

    logic [7:0] txQ[$];
    int         errIdx;
    wr_t        gotQ[$];
    wr_t        expQ[$];
    logic       expDone, expErr, expBusy;

    int   cyc = 0;
    int   lastValidCyc = -100;
    int   lastWeCyc = -100;
    int   validCount = 0;
    logic prevWe = 1'b0;
    logic prevDone = 1'b0;

    uart_program_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst  (core_rst),
        .load_done (load_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #4000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s/%s: got=%0h expected=%0h", testName, tag, got, exp);
        end
    endtask

    // Write capture and timing checks, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prevWe   = 1'b0;
            prevDone = 1'b0;
        end else begin
            if (dut.byteValid) begin
                lastValidCyc = cyc;
                validCount++;
            end
            if (imem_we) begin
                checkVal("we_one_cycle", prevWe, 0);
                checkVal("we_latency", cyc - lastValidCyc, 1);
                gotQ.push_back('{addr: int'(imem_addr), data: imem_wdata});
                lastWeCyc = cyc;
            end
            if (load_done && !prevDone) begin
                if (gotQ.size() > 0) checkVal("done_after_write", cyc - lastWeCyc, 1);
                else                 checkVal("done_after_len", cyc - lastValidCyc, 1);
            end
            prevWe   = imem_we;
            prevDone = load_done;
        end
    end

    task automatic checkResetOutputs();
        checkVal("rst_we", imem_we, 0);
        checkVal("rst_addr", imem_addr, 0);
        checkVal("rst_wdata", imem_wdata, 0);
        checkVal("rst_core_rst", core_rst, 1);
        checkVal("rst_load_done", load_done, 0);
        checkVal("rst_frame_err", frame_err, 0);
        checkVal("rst_busy", busy, 0);
    endtask

    task automatic resetDut();
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkResetOutputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        gotQ.delete();
        validCount = 0;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stopBit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (stopBit ? 2 : 2 + 3 * CPB) @(negedge clk);
    endtask

    task automatic sendStream();
        for (int i = 0; i < txQ.size(); i++) sendByte(txQ[i], i != errIdx);
        repeat (20) @(negedge clk);
    endtask

    // Stream-level model: length header, word count rules, error byte cut-off.
    task automatic modelStream();
        int n, lim, nWords, avail;
        expQ.delete();
        expDone = 1'b0;
        expErr  = 1'b0;
        expBusy = 1'b0;
        n   = txQ.size();
        lim = (errIdx >= 0) ? errIdx : n;
        if (lim < 2) begin
            if (errIdx >= 0) expErr = 1'b1;
            else             expBusy = (n == 1);
            return;
        end
        nWords = int'(txQ[0]) + 256 * int'(txQ[1]);
        if (nWords == 0) begin
            expDone = 1'b1;
            return;
        end
        if (nWords > (1 << AW)) begin
            expErr = 1'b1;
            return;
        end
        avail = (lim - 2) / 4;
        for (int i = 0; i < nWords && i < avail; i++)
            expQ.push_back('{addr: i, data: {txQ[5+4*i], txQ[4+4*i], txQ[3+4*i], txQ[2+4*i]}});
        if (avail >= nWords)  expDone = 1'b1;
        else if (errIdx >= 0) expErr  = 1'b1;
        else                  expBusy = 1'b1;
    endtask

    task automatic checkResults();
        int m;
        checkVal("n_writes", gotQ.size(), expQ.size());
        m = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
        for (int i = 0; i < m; i++) begin
            checkVal($sformatf("addr%0d", i), gotQ[i].addr, expQ[i].addr);
            checkVal($sformatf("data%0d", i), gotQ[i].data, expQ[i].data);
        end
        checkVal("load_done", load_done, expDone);
        checkVal("core_rst", core_rst, !expDone);
        checkVal("frame_err", frame_err, expErr);
        checkVal("busy", busy, expBusy);
        if (expQ.size() > 0) begin
            checkVal("hold_addr", imem_addr, expQ[expQ.size()-1].addr);
            checkVal("hold_wdata", imem_wdata, expQ[expQ.size()-1].data);
        end
    endtask

    task automatic runStream();
        modelStream();
        sendStream();
        checkResults();
    endtask

    task automatic buildRandom(input int nWords, input int extra);
        txQ.delete();
        txQ.push_back(8'(nWords));
        txQ.push_back(8'(nWords >> 8));
        for (int i = 0; i < 4 * nWords + extra; i++) txQ.push_back(8'($urandom));
    endtask

    initial begin
        rx  = 1'b1;
        rst = 1'b1;

        testName = "basic";
        resetDut();
        txQ = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h02, 8'h10, 8'h00,
                8'h01, 8'h02, 8'h03, 8'h04};
        errIdx = -1;
        runStream();
        if (gotQ.size() == 2) begin
            checkVal("word0_const", gotQ[0].data, 32'h00A00513);
            checkVal("word1_const", gotQ[1].data, 32'h00100293);
        end

        testName = "zero_len";
        resetDut();
        txQ = '{8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        errIdx = -1;
        runStream();

        testName = "oversize";
        resetDut();
        txQ = '{8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        errIdx = -1;
        runStream();

        testName = "oversize_hi";
        resetDut();
        txQ = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
        errIdx = -1;
        runStream();

        testName = "stop_err";
        resetDut();
        txQ = '{8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
        errIdx = 4;
        runStream();

        testName = "glitch_rst";
        resetDut();
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        checkVal("glitch_no_byte", validCount, 0);
        checkVal("glitch_busy", busy, 0);
        checkVal("glitch_frame_err", frame_err, 0);
        txQ = '{8'h03, 8'h00, 8'h5A, 8'hA5};
        errIdx = -1;
        sendStream();
        checkVal("partial_busy", busy, 1);
        checkVal("partial_core_rst", core_rst, 1);
        checkVal("partial_writes", gotQ.size(), 0);
        #2 rst = 1'b1;
        #1 checkResetOutputs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        gotQ.delete();
        buildRandom(3, 0);
        runStream();

        for (int t = 0; t < 6; t++) begin
            testName = $sformatf("rand%0d", t);
            resetDut();
            buildRandom(int'($urandom_range(1, 8)), int'($urandom_range(0, 3)));
            errIdx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, txQ.size() - 1)) : -1;
            runStream();
        end

        testName = "full_256";
        resetDut();
        buildRandom(256, 2);
        errIdx = -1;
        runStream();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_program_loader.md
UART_PROGRAM_LOADER -- requirements
Module: uart_program_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200 baud).
REQ-002 SHALL have parameter ADDR_W, default 8, instruction-memory word-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rx  input  1  UART serial in, idle high, 8N1, LSB first.
REQ-006 SHALL have port imem_we  output  1  instruction-memory write strobe, one-cycle pulse per word.
REQ-007 SHALL have port imem_addr  output  ADDR_W  word address of current write.
REQ-008 SHALL have port imem_wdata  output  32  instruction word being written.
REQ-009 SHALL have port core_rst  output  1  reset to processor core; high until load completes.
REQ-010 SHALL have port load_done  output  1  high once all words are written.
REQ-011 SHALL have port frame_err  output  1  sticky error: bad stop bit or oversize length.
REQ-012 SHALL have port busy  output  1  high from first length byte until DONE or ERR.

Function
REQ-013 SHALL pass rx through a two-flop synchronizer before any use.
REQ-014 SHALL detect start on synchronized rx low in idle, and re-sample at CLKS_PER_BIT/2; if high, treat as glitch and return to idle with no byte.
REQ-015 SHALL sample 8 data bits, then the stop bit, each CLKS_PER_BIT cycles apart at bit centre.
REQ-016 SHALL pulse an internal byte_valid for one cycle at the stop-bit sample when stop=1; stop=0 sets frame_err and aborts the load (ERR).
REQ-017 SHALL run loader FSM states LEN_LO, LEN_HI, DATA, DONE, ERR; reset state LEN_LO.
REQ-018 SHALL take the 16-bit word count N little-endian: LEN_LO byte -> N[7:0], LEN_HI byte -> N[15:8].
REQ-019 SHALL go LEN_HI -> DONE if N=0; -> ERR with frame_err=1 if N > 2^ADDR_W; else -> DATA.
REQ-020 SHALL assemble each word little-endian from 4 consecutive bytes (first byte -> bits 7:0).
REQ-021 SHALL assert imem_we for exactly the cycle after byte_valid of a word's 4th byte, with imem_addr = word index (0-based) and imem_wdata = assembled word stable that cycle.
REQ-022 SHALL increment the word index after each write and enter DONE the cycle after the write of word N-1.
REQ-023 SHALL hold core_rst=1 in all states except DONE; core_rst=0 and load_done=1 in DONE.
REQ-024 SHALL ignore all received bytes in DONE and ERR; both states exit only via rst.
REQ-025 SHALL keep imem_addr/imem_wdata at last written values when imem_we=0.
REQ-026 SHALL never write at address >= N; word index SHALL not wrap.

Reset
REQ-027 SHALL on rst, asynchronously: imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, load_done=0, frame_err=0, busy=0, FSM=LEN_LO, UART receiver idle, byte counter 0.
REQ-028 SHALL, on rst mid-load, abandon the partial word and restart at LEN_LO; already-written memory is not cleared.

Structure
REQ-029 SHALL place the loader state enum and default CLKS_PER_BIT/ADDR_W constants in shared package loader_pkg.
REQ-030 SHALL implement the serial receiver as sub-module uart_rx (outputs byte[7:0], byte_valid, stop_err).
REQ-031 SHALL be sized for 120-400 lines RTL total; no FIFO (one byte buffered at a time).

Verification (CLKS_PER_BIT=4, ADDR_W=8)
REQ-032 SHALL test: bytes 02 00 13 05 A0 00 93 02 10 00 -> writes addr0=0x00A00513, addr1=0x001002 93 assembled as 0x00100293, each imem_we one cycle; then core_rst=0, load_done=1.
REQ-033 SHALL test: bytes 00 00 -> no imem_we, DONE one cycle after LEN_HI byte_valid, core_rst=0.
REQ-034 SHALL test: bytes 01 01 (N=257) -> frame_err=1, ERR, core_rst stays 1, later bytes cause no writes.
REQ-035 SHALL test: stop bit driven 0 on third data byte -> frame_err=1, no write for that word, busy=0.
REQ-036 SHALL test: 1-cycle low glitch on rx in idle -> no byte_valid; then rst asserted after 2 data bytes of word 0 -> all outputs at reset values, next full stream loads from addr 0.
